// File: rtl/traffic_light_monitor_if.sv
// rtl/traffic_light_monitor_if.sv - lamp sample / status bundle for the traffic light monitor
interface traffic_light_monitor_if;
  logic [2:0] lights;
  logic       clr_err;
  logic [1:0] phase;
  logic       locked;
  logic       err_enc;
  logic       err_seq;
  logic       err_time;
  logic       err_pulse;
  logic [7:0] cycle_count;

  modport master (
    output lights, clr_err,
    input  phase, locked, err_enc, err_seq, err_time, err_pulse, cycle_count
  );

  modport slave (
    input  lights, clr_err,
    output phase, locked, err_enc, err_seq, err_time, err_pulse, cycle_count
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - checks lamp encoding, phase order and phase durations
module traffic_light_monitor #(
  parameter int unsigned RED_LEN = 5,
  parameter int unsigned GRN_LEN = 5,
  parameter int unsigned YEL_LEN = 3
) (
  input logic                    clk,
  input logic                    rst,
  traffic_light_monitor_if.slave bus
);

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_YEL = 3'b010;

  localparam logic [7:0] LEN_RED = 8'(RED_LEN);
  localparam logic [7:0] LEN_GRN = 8'(GRN_LEN);
  localparam logic [7:0] LEN_YEL = 8'(YEL_LEN);

  typedef enum logic {
    ST_SYNC  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  state_t     r_state, w_state;
  logic [2:0] r_prev, w_prev;
  logic [7:0] r_run_len, w_run_len;
  logic [1:0] r_phase, w_phase;
  logic       r_locked, w_locked;
  logic       r_err_enc, w_err_enc;
  logic       r_err_seq, w_err_seq;
  logic       r_err_time, w_err_time;
  logic       r_err_pulse, w_err_pulse;
  logic [7:0] r_cycle_count, w_cycle_count;

  logic       w_enc_ev;
  logic       w_seq_ev;
  logic       w_time_ev;
  logic [7:0] w_run_inc;
  logic       w_order_ok;
  logic       w_len_ok;

  function automatic logic is_legal(input logic [2:0] s);
    return (s == LAMP_RED) || (s == LAMP_GRN) || (s == LAMP_YEL);
  endfunction

  // Required run length for the phase a (legal) lamp value represents
  function automatic logic [7:0] len_of(input logic [2:0] s);
    case (s)
      LAMP_RED: return LEN_RED;
      LAMP_GRN: return LEN_GRN;
      LAMP_YEL: return LEN_YEL;
      default:  return 8'd0;
    endcase
  endfunction

  function automatic logic [1:0] decode(input logic [2:0] s);
    case (s)
      LAMP_RED: return 2'b00;
      LAMP_GRN: return 2'b01;
      LAMP_YEL: return 2'b10;
      default:  return 2'b11;
    endcase
  endfunction

  // Next state and registered outputs, decided from the current sample against prev
  always_comb begin
    w_state       = r_state;
    w_prev        = bus.lights;
    w_run_len     = r_run_len;
    w_phase       = decode(bus.lights);
    w_cycle_count = r_cycle_count;
    w_enc_ev      = 1'b0;
    w_seq_ev      = 1'b0;
    w_time_ev     = 1'b0;
    w_run_inc     = (r_run_len == 8'hFF) ? r_run_len : r_run_len + 8'd1;
    w_order_ok    = ((r_prev == LAMP_RED) && (bus.lights == LAMP_GRN)) ||
                    ((r_prev == LAMP_GRN) && (bus.lights == LAMP_YEL)) ||
                    ((r_prev == LAMP_YEL) && (bus.lights == LAMP_RED));
    w_len_ok      = (r_run_len == len_of(r_prev));

    if (!is_legal(bus.lights)) begin
      w_enc_ev  = 1'b1;
      w_state   = ST_SYNC;
      w_run_len = 8'd0;
      w_phase   = 2'b11;
    end else begin
      case (r_state)
        ST_SYNC: begin
          if (is_legal(r_prev) && (bus.lights != r_prev)) begin
            // First transition after sync: start counting, nothing to check yet
            w_state   = ST_TRACK;
            w_run_len = 8'd1;
          end else if (bus.lights == r_prev) begin
            w_run_len = w_run_inc;
          end else begin
            w_run_len = 8'd1;
          end
        end
        ST_TRACK: begin
          if (bus.lights == r_prev) begin
            if (r_run_len == len_of(bus.lights)) begin
              w_time_ev = 1'b1;
              w_state   = ST_SYNC;
            end else begin
              w_run_len = w_run_inc;
            end
          end else begin
            w_seq_ev  = !w_order_ok;
            w_time_ev = !w_len_ok;
            w_run_len = 8'd1;
            if (!w_order_ok || !w_len_ok) begin
              w_state = ST_SYNC;
            end else if ((r_prev == LAMP_YEL) && (r_cycle_count != 8'hFF)) begin
              w_cycle_count = r_cycle_count + 8'd1;
            end
          end
        end
        default: begin
          w_state   = ST_SYNC;
          w_run_len = 8'd0;
        end
      endcase
    end

    w_locked    = (w_state == ST_TRACK);
    // A fresh error beats a clear request on the same edge
    w_err_enc   = (r_err_enc  && !bus.clr_err) || w_enc_ev;
    w_err_seq   = (r_err_seq  && !bus.clr_err) || w_seq_ev;
    w_err_time  = (r_err_time && !bus.clr_err) || w_time_ev;
    w_err_pulse = w_enc_ev || w_seq_ev || w_time_ev;
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_SYNC;
      r_prev        <= 3'b000;
      r_run_len     <= 8'd0;
      r_phase       <= 2'b11;
      r_locked      <= 1'b0;
      r_err_enc     <= 1'b0;
      r_err_seq     <= 1'b0;
      r_err_time    <= 1'b0;
      r_err_pulse   <= 1'b0;
      r_cycle_count <= 8'd0;
    end else begin
      r_state       <= w_state;
      r_prev        <= w_prev;
      r_run_len     <= w_run_len;
      r_phase       <= w_phase;
      r_locked      <= w_locked;
      r_err_enc     <= w_err_enc;
      r_err_seq     <= w_err_seq;
      r_err_time    <= w_err_time;
      r_err_pulse   <= w_err_pulse;
      r_cycle_count <= w_cycle_count;
    end
  end

  assign bus.phase       = r_phase;
  assign bus.locked      = r_locked;
  assign bus.err_enc     = r_err_enc;
  assign bus.err_seq     = r_err_seq;
  assign bus.err_time    = r_err_time;
  assign bus.err_pulse   = r_err_pulse;
  assign bus.cycle_count = r_cycle_count;

endmodule
